// File: rtl/dtcm_pkg.sv
// Shared constants and port-select encoding for the data-TCM controller slice.
package dtcm_pkg;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_EXT  = 1'b1
  } port_sel_e;

  localparam int unsigned DTCM_BSW = 4;
  localparam int unsigned DTCM_DW  = 32;

endpackage

// File: rtl/dtcm_if.sv
// Core data port and external (DMA/debug) port into the DTCM controller.
interface dtcm_if;
  import dtcm_pkg::*;

  logic                data_dtcm_access;
  logic                data_dtcm_ready;
  logic                data_dtcm_rd0_wr1;
  logic [DTCM_BSW-1:0] data_dtcm_byte_strobe;
  logic [DTCM_DW-1:0]  data_dtcm_write_data;
  logic [31:0]         data_dtcm_addr;
  logic [DTCM_DW-1:0]  data_dtcm_read_data;
  logic                data_dtcm_read_data_valid;

  logic                ext_dtcm_req;
  logic                ext_dtcm_gnt;
  logic                ext_dtcm_rd0_wr1;
  logic [DTCM_BSW-1:0] ext_dtcm_byte_strobe;
  logic [DTCM_DW-1:0]  ext_dtcm_write_data;
  logic [31:0]         ext_dtcm_addr;
  logic [DTCM_DW-1:0]  ext_dtcm_read_data;
  logic                ext_dtcm_read_data_valid;

  modport master (
    output data_dtcm_access, data_dtcm_rd0_wr1, data_dtcm_byte_strobe,
           data_dtcm_write_data, data_dtcm_addr,
           ext_dtcm_req, ext_dtcm_rd0_wr1, ext_dtcm_byte_strobe,
           ext_dtcm_write_data, ext_dtcm_addr,
    input  data_dtcm_ready, data_dtcm_read_data, data_dtcm_read_data_valid,
           ext_dtcm_gnt, ext_dtcm_read_data, ext_dtcm_read_data_valid
  );

  modport slave (
    input  data_dtcm_access, data_dtcm_rd0_wr1, data_dtcm_byte_strobe,
           data_dtcm_write_data, data_dtcm_addr,
           ext_dtcm_req, ext_dtcm_rd0_wr1, ext_dtcm_byte_strobe,
           ext_dtcm_write_data, ext_dtcm_addr,
    output data_dtcm_ready, data_dtcm_read_data, data_dtcm_read_data_valid,
           ext_dtcm_gnt, ext_dtcm_read_data, ext_dtcm_read_data_valid
  );

endinterface

// File: rtl/dtcm_ram.sv
// Single-port synchronous SRAM, byte write enables, registered write-first read.
module dtcm_ram
  import dtcm_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DTCM_BSW-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DTCM_DW-1:0]  wdata,
  output logic [DTCM_DW-1:0]  rdata
);

  logic [DTCM_DW-1:0] mem [0:(2**AW)-1];
  logic [DTCM_DW-1:0] wr_word;

  always_comb begin
    wr_word = mem[addr];
    for (int unsigned i = 0; i < DTCM_BSW; i++) begin
      if (we && be[i]) wr_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wr_word;
      rdata <= wr_word;
    end
  end

endmodule

// File: rtl/dtcm_ctrl.sv
// DTCM responder: core-priority arbitration with external starvation guard,
// one-cycle read return steered to the requesting port.
module dtcm_ctrl
  import dtcm_pkg::*;
#(
  parameter int unsigned DTCM_AW    = 14,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic     cpu_clk,
  input logic     cpu_rst,
  dtcm_if.slave   bus
);

  localparam int unsigned   SCW        = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0]      starve_cnt;
  logic                force_ext;
  port_sel_e           resp_sel;
  logic                rd_pend;
  logic [DTCM_DW-1:0]  core_hold, ext_hold, ram_rdata;

  logic                core_rd, core_wr, core_acc, ext_acc;
  logic                core_vld, ext_vld;
  port_sel_e           sel;
  logic                ram_en, ram_we;
  logic [DTCM_BSW-1:0] ram_be;
  logic [DTCM_AW-1:0]  ram_addr;
  logic [DTCM_DW-1:0]  ram_wdata;
  logic                unused_addr_bits;

  // Core loads are never refused; only core stores yield to a forced external slot.
  assign core_rd  = !cpu_rst && bus.data_dtcm_access && !bus.data_dtcm_rd0_wr1;
  assign core_wr  = !cpu_rst && bus.data_dtcm_access &&  bus.data_dtcm_rd0_wr1 && !force_ext;
  assign core_acc = core_rd || core_wr;
  assign ext_acc  = !cpu_rst && bus.ext_dtcm_req && !core_acc;

  assign bus.data_dtcm_ready = !force_ext;
  assign bus.ext_dtcm_gnt    = ext_acc;

  always_comb begin
    sel       = core_acc ? PORT_CORE : PORT_EXT;
    ram_en    = core_acc || ext_acc;
    ram_we    = core_acc ? bus.data_dtcm_rd0_wr1     : bus.ext_dtcm_rd0_wr1;
    ram_be    = core_acc ? bus.data_dtcm_byte_strobe : bus.ext_dtcm_byte_strobe;
    ram_wdata = core_acc ? bus.data_dtcm_write_data  : bus.ext_dtcm_write_data;
    ram_addr  = core_acc ? bus.data_dtcm_addr[DTCM_AW+1:2] : bus.ext_dtcm_addr[DTCM_AW+1:2];
  end

  assign unused_addr_bits = &{1'b0,
                              bus.data_dtcm_addr[31:DTCM_AW+2], bus.data_dtcm_addr[1:0],
                              bus.ext_dtcm_addr[31:DTCM_AW+2],  bus.ext_dtcm_addr[1:0]};

  dtcm_ram #(.AW(DTCM_AW)) u_ram (
    .clk   (cpu_clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      starve_cnt <= '0;
      force_ext  <= 1'b0;
      resp_sel   <= PORT_CORE;
      rd_pend    <= 1'b0;
      core_hold  <= '0;
      ext_hold   <= '0;
    end else begin
      if (!bus.ext_dtcm_req || ext_acc) begin
        starve_cnt <= '0;
        force_ext  <= 1'b0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + SCW'(1);
        force_ext  <= (starve_cnt + SCW'(1)) == STARVE_LIM;
      end
      rd_pend <= ram_en && !ram_we;
      if (ram_en && !ram_we) resp_sel <= sel;
      if (core_vld) core_hold <= ram_rdata;
      if (ext_vld)  ext_hold  <= ram_rdata;
    end
  end

  // Masking with cpu_rst drops a read that lands in the reset cycle itself.
  assign core_vld = !cpu_rst && rd_pend && (resp_sel == PORT_CORE);
  assign ext_vld  = !cpu_rst && rd_pend && (resp_sel == PORT_EXT);

  assign bus.data_dtcm_read_data_valid = core_vld;
  assign bus.ext_dtcm_read_data_valid  = ext_vld;
  assign bus.data_dtcm_read_data = cpu_rst ? '0 : (core_vld ? ram_rdata : core_hold);
  assign bus.ext_dtcm_read_data  = cpu_rst ? '0 : (ext_vld  ? ram_rdata : ext_hold);

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Self-checking bench for dtcm_ctrl against a word-array reference model.
module tb_dtcm_ctrl;
  import dtcm_pkg::*;

  localparam int unsigned AW   = 14;
  localparam int          SMAX = 8;

  logic cpu_clk;
  logic cpu_rst;

  dtcm_if bus();

  dtcm_ctrl #(.DTCM_AW(AW), .STARVE_MAX(SMAX)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic [31:0] mmem [0:(1<<AW)-1];
  int          m_starve;
  bit          exp_ready, exp_gnt, exp_cv, exp_ev;
  logic [31:0] exp_cd, exp_ed;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % (32'd1 << AW));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic model_reset();
    m_starve = 0;
    exp_cv = 0; exp_ev = 0;
    exp_cd = '0; exp_ed = '0;
  endtask

  // Drives one cycle of requests, then predicts grants and next-cycle responses.
  task automatic step(input bit c_acc, input bit c_wr, input logic [3:0] c_be,
                      input logic [31:0] c_wd, input logic [31:0] c_ad,
                      input bit e_req, input bit e_wr, input logic [3:0] e_be,
                      input logic [31:0] e_wd, input logic [31:0] e_ad);
    bit c_rd_ok, c_wr_ok;
    bus.data_dtcm_access      = c_acc;
    bus.data_dtcm_rd0_wr1     = c_wr;
    bus.data_dtcm_byte_strobe = c_be;
    bus.data_dtcm_write_data  = c_wd;
    bus.data_dtcm_addr        = c_ad;
    bus.ext_dtcm_req          = e_req;
    bus.ext_dtcm_rd0_wr1      = e_wr;
    bus.ext_dtcm_byte_strobe  = e_be;
    bus.ext_dtcm_write_data   = e_wd;
    bus.ext_dtcm_addr         = e_ad;
    #1;
    exp_ready = (m_starve < SMAX);
    c_rd_ok   = c_acc && !c_wr;
    c_wr_ok   = c_acc && c_wr && exp_ready;
    exp_gnt   = e_req && !c_rd_ok && !c_wr_ok;
    exp_cv    = c_rd_ok;
    exp_ev    = exp_gnt && !e_wr;
    if (c_rd_ok)      exp_cd = mmem[widx(c_ad)];
    else if (c_wr_ok) mmem[widx(c_ad)] = merge(mmem[widx(c_ad)], c_wd, c_be);
    else if (exp_gnt) begin
      if (e_wr) mmem[widx(e_ad)] = merge(mmem[widx(e_ad)], e_wd, e_be);
      else      exp_ed = mmem[widx(e_ad)];
    end
    m_starve = (e_req && !exp_gnt) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
  endtask

  task automatic idle();
    step(0, 0, 4'h0, '0, '0, 0, 0, 4'h0, '0, '0);
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    idle();
    repeat (3) tick();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
         bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data} !== '0)
      $display("FAIL reset_outputs: got %b/%h %b/%h expected all zero",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
               bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data);
    else n_pass++;
    cpu_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.data_dtcm_ready !== 1'b1)
      $display("FAIL reset_ready: got %b expected 1", bus.data_dtcm_ready);
    else n_pass++;
  endtask

  task automatic test_preload();
    logic [31:0] v;
    for (int w = 0; w < 64; w++) begin
      v = (w == 4) ? 32'hDEADBEEF : (w == 8) ? 32'h11223344 : $urandom;
      step(1, 1, 4'hF, v, 32'(w * 4), 0, 0, 4'h0, '0, '0);
      n_checks++;
      if (bus.data_dtcm_ready !== 1'b1 || bus.ext_dtcm_gnt !== 1'b0)
        $display("FAIL preload_write: ready=%b gnt=%b expected 1/0",
                 bus.data_dtcm_ready, bus.ext_dtcm_gnt);
      else n_pass++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_core_read();
    step(1, 0, 4'h0, '0, 32'h10, 0, 0, 4'h0, '0, '0);
    tick();
    idle();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL core_read: got %b/%h expected 1/deadbeef",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data);
    else n_pass++;
    n_checks++;
    if (bus.ext_dtcm_read_data_valid !== 1'b0)
      $display("FAIL core_read_ext_quiet: ext valid %b expected 0", bus.ext_dtcm_read_data_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL core_read_hold: got %b/%h expected 0/deadbeef",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    step(1, 1, 4'b0100, 32'h00AB0000, 32'h20, 0, 0, 4'h0, '0, '0);
    tick();
    n_checks++;
    if (bus.data_dtcm_read_data_valid !== 1'b0)
      $display("FAIL byte_write_no_resp: valid %b expected 0", bus.data_dtcm_read_data_valid);
    else n_pass++;
    step(1, 0, 4'h0, '0, 32'h20, 0, 0, 4'h0, '0, '0);
    tick();
    idle();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data} !== {1'b1, 32'h11AB3344})
      $display("FAIL byte_write_merge: got %b/%h expected 1/11ab3344",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    logic [31:0] wd;
    for (int i = 0; i < SMAX; i++) begin
      if (i % 2 == 0) step(1, 0, 4'h0, '0, 32'(i * 4), 1, 0, 4'h0, '0, 32'h30);
      else            step(1, 1, 4'hF, $urandom, 32'(32'h80 + i * 4), 1, 0, 4'h0, '0, 32'h30);
      n_checks++;
      if ({bus.data_dtcm_ready, bus.ext_dtcm_gnt} !== 2'b10)
        $display("FAIL starve_deny[%0d]: ready/gnt %b%b expected 10", i,
                 bus.data_dtcm_ready, bus.ext_dtcm_gnt);
      else n_pass++;
      tick();
    end
    step(1, 0, 4'h0, '0, 32'h0, 1, 0, 4'h0, '0, 32'h30);
    n_checks++;
    if ({bus.data_dtcm_ready, bus.ext_dtcm_gnt} !== 2'b00)
      $display("FAIL starve_force_read: ready/gnt %b%b expected 00",
               bus.data_dtcm_ready, bus.ext_dtcm_gnt);
    else n_pass++;
    tick();
    wd = 32'hA5A55A5A;
    step(1, 1, 4'hF, wd, 32'h84, 1, 0, 4'h0, '0, 32'h30);
    n_checks++;
    if ({bus.data_dtcm_ready, bus.ext_dtcm_gnt} !== 2'b01)
      $display("FAIL starve_force_gnt: ready/gnt %b%b expected 01",
               bus.data_dtcm_ready, bus.ext_dtcm_gnt);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data} !== {1'b1, exp_ed})
      $display("FAIL starve_ext_data: got %b/%h expected 1/%h",
               bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data, exp_ed);
    else n_pass++;
    step(1, 1, 4'hF, wd, 32'h84, 0, 0, 4'h0, '0, '0);
    n_checks++;
    if (bus.data_dtcm_ready !== 1'b1)
      $display("FAIL starve_ready_back: ready %b expected 1", bus.data_dtcm_ready);
    else n_pass++;
    tick();
    step(1, 0, 4'h0, '0, 32'h84, 0, 0, 4'h0, '0, '0);
    tick();
    idle();
    n_checks++;
    if (bus.data_dtcm_read_data !== wd)
      $display("FAIL starve_held_write: got %h expected %h", bus.data_dtcm_read_data, wd);
    else n_pass++;
    tick();
  endtask

  task automatic test_same_word();
    logic [31:0] old;
    old = mmem[widx(32'h50)];
    step(1, 0, 4'h0, '0, 32'h50, 1, 1, 4'hF, 32'hCAFEF00D, 32'h50);
    n_checks++;
    if (bus.ext_dtcm_gnt !== 1'b0)
      $display("FAIL same_word_gnt: gnt %b expected 0", bus.ext_dtcm_gnt);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data} !== {1'b1, old})
      $display("FAIL same_word_old: got %b/%h expected 1/%h",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data, old);
    else n_pass++;
    step(0, 0, 4'h0, '0, '0, 1, 1, 4'hF, 32'hCAFEF00D, 32'h50);
    n_checks++;
    if (bus.ext_dtcm_gnt !== 1'b1)
      $display("FAIL same_word_late_gnt: gnt %b expected 1", bus.ext_dtcm_gnt);
    else n_pass++;
    tick();
    step(1, 0, 4'h0, '0, 32'h50, 0, 0, 4'h0, '0, '0);
    tick();
    idle();
    n_checks++;
    if (bus.data_dtcm_read_data !== 32'hCAFEF00D)
      $display("FAIL same_word_new: got %h expected cafef00d", bus.data_dtcm_read_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_interleave();
    logic [31:0] w0, w1;
    w0 = mmem[0];
    w1 = mmem[1];
    step(1, 0, 4'h0, '0, 32'h0, 0, 0, 4'h0, '0, '0);
    tick();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.ext_dtcm_read_data_valid, bus.data_dtcm_read_data}
        !== {2'b10, w0})
      $display("FAIL interleave_core: valids %b%b data %h expected 10/%h",
               bus.data_dtcm_read_data_valid, bus.ext_dtcm_read_data_valid,
               bus.data_dtcm_read_data, w0);
    else n_pass++;
    step(0, 0, 4'h0, '0, '0, 1, 0, 4'h0, '0, 32'h4);
    tick();
    idle();
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data}
        !== {2'b01, w1})
      $display("FAIL interleave_ext: valids %b%b data %h expected 01/%h",
               bus.data_dtcm_read_data_valid, bus.ext_dtcm_read_data_valid,
               bus.ext_dtcm_read_data, w1);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'h0, '0, 32'(i * 4), 1, 0, 4'h0, '0, 32'h8);
      tick();
    end
    cpu_rst = 1'b1;
    bus.data_dtcm_access = 1'b0;
    bus.ext_dtcm_req     = 1'b0;
    #1;
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
         bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data} !== '0)
      $display("FAIL reset_inflight_drop: got %b/%h %b/%h expected all zero",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
               bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data);
    else n_pass++;
    tick();
    cpu_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
         bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data} !== '0)
      $display("FAIL reset_inflight_after: got %b/%h %b/%h expected all zero",
               bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
               bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data);
    else n_pass++;
    for (int i = 0; i < SMAX - 1; i++) begin
      step(1, 0, 4'h0, '0, 32'(i * 4), 1, 0, 4'h0, '0, 32'h8);
      tick();
    end
    step(0, 0, 4'h0, '0, '0, 1, 0, 4'h0, '0, 32'h8);
    n_checks++;
    if ({bus.data_dtcm_ready, bus.ext_dtcm_gnt} !== 2'b11)
      $display("FAIL reset_starve_clear: ready/gnt %b%b expected 11",
               bus.data_dtcm_ready, bus.ext_dtcm_gnt);
    else n_pass++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    bit          c_acc = 0, c_wr = 0, e_req = 0, e_wr = 0, c_pend = 0, e_pend = 0;
    logic [3:0]  c_be = '0, e_be = '0;
    logic [31:0] c_wd = '0, c_ad = '0, e_wd = '0, e_ad = '0;
    for (int n = 0; n < 400; n++) begin
      if (!c_pend) begin
        c_acc = ($urandom_range(0, 99) < 65);
        c_wr  = $urandom_range(0, 1) == 1;
        c_be  = 4'($urandom);
        c_wd  = $urandom;
        c_ad  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2)
                | 32'($urandom_range(0, 3));
      end
      if (!e_pend) begin
        e_req = ($urandom_range(0, 99) < 50);
        e_wr  = $urandom_range(0, 1) == 1;
        e_be  = 4'($urandom);
        e_wd  = $urandom;
        e_ad  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2)
                | 32'($urandom_range(0, 3));
      end
      step(c_acc, c_wr, c_be, c_wd, c_ad, e_req, e_wr, e_be, e_wd, e_ad);
      n_checks++;
      if ({bus.data_dtcm_ready, bus.ext_dtcm_gnt} !== {exp_ready, exp_gnt})
        $display("FAIL rand_grant[%0d]: ready/gnt %b%b expected %b%b", n,
                 bus.data_dtcm_ready, bus.ext_dtcm_gnt, exp_ready, exp_gnt);
      else n_pass++;
      c_pend = c_acc && c_wr && !exp_ready;
      e_pend = e_req && !exp_gnt;
      tick();
      n_checks++;
      if ({bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
           bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data}
          !== {exp_cv, exp_cd, exp_ev, exp_ed})
        $display("FAIL rand_resp[%0d]: core %b/%h ext %b/%h expected core %b/%h ext %b/%h", n,
                 bus.data_dtcm_read_data_valid, bus.data_dtcm_read_data,
                 bus.ext_dtcm_read_data_valid, bus.ext_dtcm_read_data,
                 exp_cv, exp_cd, exp_ev, exp_ed);
      else n_pass++;
    end
    idle();
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_preload();
    test_core_read();
    test_byte_write();
    test_starve();
    test_same_word();
    test_interleave();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
